// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared FSM state encoding, port indices and the address
// range check used by the data-memory arbiter.
package dm_arb_pkg;

  // Sequencer states: pick a winner, touch memory, report back
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Requester indices as they appear on o_gnt
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // A word access is illegal when it is not word aligned or when any of its
  // four bytes would fall past the end of memory. The compare is a plain
  // 32-bit unsigned one, so high addresses never wrap back into range.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > (mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundles the two requester handshakes, the data-memory
// strobes/buses and the arbiter status lines. The arbiter connects through
// the slave modport; the requesters and memory model use the master modport.
interface dm_arbiter_if;

  // Requester 0 (CPU MEM stage)
  logic        i_req0;
  logic        i_we0;
  logic [31:0] i_addr0;
  logic [31:0] i_wdata0;
  logic        o_ack0;
  logic        o_err0;
  logic [31:0] o_rdata0;

  // Requester 1 (loader / debug)
  logic        i_req1;
  logic        i_we1;
  logic [31:0] i_addr1;
  logic [31:0] i_wdata1;
  logic        o_ack1;
  logic        o_err1;
  logic [31:0] o_rdata1;

  // Data memory side
  logic        o_MemRead;
  logic        o_MemWrite;
  logic [31:0] o_dm_addr;
  logic [31:0] o_dm_wdata;
  logic [31:0] i_dm_rdata;

  // Status
  logic        o_busy;
  logic        o_gnt;

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wdata0,
    input  i_req1, i_we1, i_addr1, i_wdata1,
    input  i_dm_rdata,
    output o_ack0, o_err0, o_rdata0,
    output o_ack1, o_err1, o_rdata1,
    output o_MemRead, o_MemWrite, o_dm_addr, o_dm_wdata,
    output o_busy, o_gnt
  );

  modport master (
    output i_req0, i_we0, i_addr0, i_wdata0,
    output i_req1, i_we1, i_addr1, i_wdata1,
    output i_dm_rdata,
    input  o_ack0, o_err0, o_rdata0,
    input  o_ack1, o_err1, o_rdata1,
    input  o_MemRead, o_MemWrite, o_dm_addr, o_dm_wdata,
    input  o_busy, o_gnt
  );

endinterface

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational winner selection between the two requesters.
// prio names the port that wins when both request at once.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic idx
);

  // A lone requester always wins; a tie goes to the favoured port
  always_comb begin
    valid = req0 | req1;
    idx   = PORT_CPU;
    if (req0 && req1) begin
      idx = prio;
    end else if (req1) begin
      idx = PORT_DBG;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter and access sequencer for the 256-byte
// big-endian data memory. One transaction at a time runs IDLE -> ACCESS ->
// RESP; the winner's request is latched in IDLE so every memory-side output
// comes from registers, never straight from a req line.
// Optional feature macro: DM_ARB_RR_EN (round-robin tie breaking; when
// undefined, port 0 has fixed priority and no pointer register exists).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  dm_arbiter_if.slave   bus
);

  arb_state_e  state_q;
  arb_state_e  state_d;

  logic        gnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        prio;
  logic        pick_valid;
  logic        pick_idx;
  logic        grant;
  logic        err_w;

  logic        mem_read;
  logic        mem_write;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [31:0] resp_rdata;

  dm_arb_pick u_pick (
    .req0  (bus.i_req0),
    .req1  (bus.i_req1),
    .prio  (prio),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Requests only count while idle; this is the single grant point
  assign grant = (state_q == ST_IDLE) && pick_valid;

  // The range check looks at the latched address, so it is stable for the
  // whole transaction and shared by the strobe and response logic
  assign err_w = addr_err(addr_q, 32'(MEM_BYTES));

`ifdef DM_ARB_RR_EN
  logic prio_q;

  // Tie-break pointer: after each grant the other port becomes favoured
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_q <= PORT_CPU;
    end else if (grant) begin
      prio_q <= ~pick_idx;
    end
  end

  assign prio = prio_q;
`else
  assign prio = PORT_CPU;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner's request at grant time; held through ACCESS and RESP
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gnt_q   <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (grant) begin
      gnt_q   <= pick_idx;
      we_q    <= (pick_idx == PORT_DBG) ? bus.i_we1    : bus.i_we0;
      addr_q  <= (pick_idx == PORT_DBG) ? bus.i_addr1  : bus.i_addr0;
      wdata_q <= (pick_idx == PORT_DBG) ? bus.i_wdata1 : bus.i_wdata0;
    end
  end

  // Capture memory read data at the end of a valid read ACCESS cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= 32'd0;
    end else if ((state_q == ST_ACCESS) && !we_q && !err_w) begin
      rdata_q <= bus.i_dm_rdata;
    end
  end

  // Next state plus all decoded outputs; strobes only in a legal ACCESS,
  // acknowledge only in RESP and only toward the granted port
  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    rdata0     = 32'd0;
    rdata1     = 32'd0;
    resp_rdata = (!we_q && !err_w) ? rdata_q : 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d   = ST_RESP;
        mem_read  = !err_w && !we_q;
        mem_write = !err_w && we_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (gnt_q == PORT_DBG) begin
          ack1   = 1'b1;
          err1   = err_w;
          rdata1 = resp_rdata;
        end else begin
          ack0   = 1'b1;
          err0   = err_w;
          rdata0 = resp_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_MemRead  = mem_read;
  assign bus.o_MemWrite = mem_write;
  assign bus.o_dm_addr  = addr_q;
  assign bus.o_dm_wdata = wdata_q;
  assign bus.o_ack0     = ack0;
  assign bus.o_ack1     = ack1;
  assign bus.o_err0     = err0;
  assign bus.o_err1     = err1;
  assign bus.o_rdata0   = rdata0;
  assign bus.o_rdata1   = rdata1;
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_gnt      = gnt_q;

endmodule
